spiker_reader: RTL

Input-side counterpart of the spiker result path. Snapshots the spike-input CSRs (N_SPIKES bits packed into N_REG_IN words of WIDTH bits) when software issues a start. Streams the snapshot to the spiker core as CHUNK-bit beats over a valid/ready interface. Reports busy/done/overrun status back to the register file.

---
 rtl/spiker_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spiker_reader.sv
// spiker_reader: input-side streamer for the spiker core.
// A start pulse snapshots the spike-input CSRs into a shadow buffer.
// The shadow is then streamed as CHUNK-bit beats over valid/ready.
// Busy, done and a sticky overrun flag are reported for the status CSR.
// Optional macro SPIKER_READER_SKIP_ZERO_EN enables event-driven mode,
// in which all-zero beats (except the last) are skipped without a handshake.
module spiker_reader #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int N_REG_IN = 25,
  parameter int CHUNK    = 16,
  localparam int N_BEATS = (N_SPIKES + CHUNK - 1) / CHUNK,
  localparam int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REG_IN*WIDTH-1:0] reg_spikes_i,
  input  logic                      start_i,
  output logic [CHUNK-1:0]          spike_o,
  output logic                      spike_valid_o,
  input  logic                      spike_ready_i,
  output logic                      spike_last_o,
  output logic [IDX_W-1:0]          spike_idx_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overrun_o
);

  localparam int SHADOW_W = N_BEATS * CHUNK;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SHADOW_W-1:0] shadow_q;
  logic [SHADOW_W-1:0] capture;
  logic                overrun_q;

  logic [CHUNK-1:0]    cur_beat;
  logic                is_last;
  logic                streaming;
  logic                beat_valid;
  logic                handshake;
  logic                unused_pad;

  // CSR bits beyond N_SPIKES never reach the shadow; fold them here so they
  // are visibly consumed.
  assign unused_pad = ^reg_spikes_i;

  // Build the snapshot image: real spikes copied, padding bits forced to zero.
  always_comb begin
    capture = '0;
    for (int i = 0; i < N_SPIKES; i++) begin
      capture[i] = reg_spikes_i[i];
    end
  end

  assign cur_beat  = shadow_q[int'(idx_q)*CHUNK +: CHUNK];
  assign is_last   = (idx_q == IDX_W'(N_BEATS - 1));
  assign streaming = (state_q == ST_STREAM);

`ifdef SPIKER_READER_SKIP_ZERO_EN
  logic skip_beat;
  assign skip_beat  = streaming && (cur_beat == '0) && !is_last;
  assign beat_valid = streaming && !skip_beat;
`else
  assign beat_valid = streaming;
`endif

  assign handshake = beat_valid && spike_ready_i;

  // Frame sequencer: capture on start, advance the beat index on each
  // accepted (or skipped) beat, and spend one cycle in DONE at the end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shadow_q <= capture;
            idx_q    <= '0;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
`ifdef SPIKER_READER_SKIP_ZERO_EN
          if (skip_beat) begin
            idx_q <= idx_q + IDX_W'(1);
          end else
`endif
          if (handshake) begin
            if (is_last) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: set by any start outside IDLE, cleared by an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
    end else if (start_i) begin
      overrun_q <= (state_q != ST_IDLE);
    end
  end

  assign spike_o       = streaming ? cur_beat : '0;
  assign spike_valid_o = beat_valid;
  assign spike_last_o  = streaming && is_last;
  assign spike_idx_o   = streaming ? idx_q : '0;
  assign busy_o        = streaming;
  assign done_o        = (state_q == ST_DONE);
  assign overrun_o     = overrun_q;

endmodule
